store_align_unit: RTL and testbench

- Store-side counterpart of the load-extract logic in the MEM/WB path of the MIPS core.
- Takes SB/SH/SW requests from the MEM stage and replicates the store data onto the correct byte lanes.
- Generates byte strobes and checks alignment, raising AdES with the bad address.
- Drives the data-SRAM-like bus through a req/addr_ok/data_ok handshake and stalls the pipeline until the write completes.

---
 rtl/store_align_unit_pkg.sv | 19 +
 rtl/store_lane_gen.sv | 55 +++++
 rtl/store_align_unit.sv | 116 +++++++++++
 tb/tb_store_align_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_align_unit_pkg.sv
// Shared opcodes, bus size codes and FSM states
// for the MEM-stage store path.
package store_align_unit_pkg;

  localparam logic [7:0] EXE_SB_OP = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP = 8'b11101011;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } st_t;

endpackage

// File: rtl/store_lane_gen.sv
// Byte-lane strobe / data replication and
// alignment check for SB, SH and SW.
module store_lane_gen
  import store_align_unit_pkg::*;
(
  input  logic [7:0]  alucontrol,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [1:0]  size,
  output logic        is_store,
  output logic        misaligned
);

  logic sb;
  logic sh;
  logic sw;

  assign sb = (alucontrol == EXE_SB_OP);
  assign sh = (alucontrol == EXE_SH_OP);
  assign sw = (alucontrol == EXE_SW_OP);

  always_comb begin
    wstrb      = 4'b0000;
    wdata_rep  = '0;
    size       = SIZE_BYTE;
    is_store   = 1'b0;
    misaligned = 1'b0;
    unique case (1'b1)
      sb: begin
        is_store  = 1'b1;
        size      = SIZE_BYTE;
        wstrb     = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
      end
      sh: begin
        is_store   = 1'b1;
        size       = SIZE_HALF;
        misaligned = addr[0];
        wstrb      = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
      end
      sw: begin
        is_store   = 1'b1;
        size       = SIZE_WORD;
        misaligned = |addr;
        wstrb      = 4'b1111;
        wdata_rep  = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_align_unit.sv
// MEM-stage store unit: AdES detection and
// req/addr_ok/data_ok write handshake with stall.
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_en,
  input  logic [7:0]        alucontrolM,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [DATA_W-1:0] wdataM,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  output logic              stall_store,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr
);

  logic [3:0]        strb;
  logic [DATA_W-1:0] wrep;
  logic [1:0]        sz;
  logic              is_st;
  logic              mis;
  logic              start;
  logic              done;
  st_t               state_q;
  st_t               state_d;

  store_lane_gen u_lane (
    .alucontrol (alucontrolM),
    .addr       (addrM[1:0]),
    .wdata      (wdataM),
    .wstrb      (strb),
    .wdata_rep  (wrep),
    .size       (sz),
    .is_store   (is_st),
    .misaligned (mis)
  );

  assign ades     = mem_en & is_st & mis;
  assign badvaddr = ades ? addrM : '0;

  assign start = mem_en & is_st & ~mis & ~flush
               & (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // an accepted write cannot be cancelled
        if (data_data_ok) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // release on completion so MEM advances on that edge
  assign stall_store = start
                     | ((state_q != ST_IDLE) & ~done);

  assign data_req = (state_q == ST_REQ);
  assign data_wr  = data_req;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      data_addr  <= '0;
      data_size  <= SIZE_BYTE;
      data_wstrb <= 4'b0000;
      data_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        data_addr  <= addrM;
        data_size  <= sz;
        data_wstrb <= strb;
        data_wdata <= wrep;
      end
    end
  end

  a_data_ok_order: assert property (
    @(posedge clk) disable iff (!resetn)
    !(data_data_ok && ((state_q == ST_IDLE) ||
      ((state_q == ST_REQ) && !data_addr_ok))));

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench: vector table for lane/AdES
// decode plus handshake, flush and reset sequences.
module tb_store_align_unit;
  import store_align_unit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_en = 1'b0;
  logic [7:0]  alucontrolM = '0;
  logic [31:0] addrM = '0;
  logic [31:0] wdataM = '0;
  logic        flush = 1'b0;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic        stall_store;
  logic        ades;
  logic [31:0] badvaddr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ades;
    logic        go;
    logic [3:0]  strb;
    logic [31:0] rep;
    logic [1:0]  size;
  } vec_t;

  vec_t vt[12];

  store_align_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_en       (mem_en),
    .alucontrolM  (alucontrolM),
    .addrM        (addrM),
    .wdataM       (wdataM),
    .flush        (flush),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .stall_store  (stall_store),
    .ades         (ades),
    .badvaddr     (badvaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] op,
                     input logic [31:0] a,
                     input logic [31:0] d);
    mem_en = 1'b1;
    alucontrolM = op;
    addrM = a;
    wdataM = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int sc;
    int rc;
    vt[0]  = '{EXE_SB_OP, 32'h1000, 32'h12345678,
               1'b0, 1'b1, 4'b0001, 32'h78787878, 2'd0};
    vt[1]  = '{EXE_SB_OP, 32'h1001, 32'h12345678,
               1'b0, 1'b1, 4'b0010, 32'h78787878, 2'd0};
    vt[2]  = '{EXE_SB_OP, 32'h1002, 32'h000000A5,
               1'b0, 1'b1, 4'b0100, 32'hA5A5A5A5, 2'd0};
    vt[3]  = '{EXE_SH_OP, 32'h2000, 32'h0000BEEF,
               1'b0, 1'b1, 4'b0011, 32'hBEEFBEEF, 2'd1};
    vt[4]  = '{EXE_SH_OP, 32'h2002, 32'h0000BEEF,
               1'b0, 1'b1, 4'b1100, 32'hBEEFBEEF, 2'd1};
    vt[5]  = '{EXE_SH_OP, 32'h3003, 32'h0000BEEF,
               1'b1, 1'b0, 4'b0000, 32'h0, 2'd0};
    vt[6]  = '{EXE_SH_OP, 32'h3001, 32'h0000BEEF,
               1'b1, 1'b0, 4'b0000, 32'h0, 2'd0};
    vt[7]  = '{EXE_SW_OP, 32'h3001, 32'h11111111,
               1'b1, 1'b0, 4'b0000, 32'h0, 2'd0};
    vt[8]  = '{EXE_SW_OP, 32'h3002, 32'h11111111,
               1'b1, 1'b0, 4'b0000, 32'h0, 2'd0};
    vt[9]  = '{EXE_SW_OP, 32'h4000, 32'hDEADBEEF,
               1'b0, 1'b1, 4'b1111, 32'hDEADBEEF, 2'd2};
    vt[10] = '{8'h00, 32'h5001, 32'hFFFFFFFF,
               1'b0, 1'b0, 4'b0000, 32'h0, 2'd0};
    vt[11] = '{EXE_SB_OP, 32'h5003, 32'h9ABCDEF0,
               1'b0, 1'b1, 4'b1000, 32'hF0F0F0F0, 2'd0};

    // reset state
    tick();
    tick();
    chk("rst_req", data_req, 1'b0);
    chk("rst_wstrb", data_wstrb, 4'b0);
    chk("rst_stall", stall_store, 1'b0);
    chk("rst_ades", ades, 1'b0);
    chk("rst_addr", data_addr, 32'h0);
    resetn = 1'b1;

    foreach (vt[i]) begin
      tick();
      put(vt[i].op, vt[i].addr, vt[i].wd);
      #1;
      chk($sformatf("v%0d_ades", i), ades, vt[i].ades);
      chk($sformatf("v%0d_badv", i), badvaddr,
          vt[i].ades ? vt[i].addr : 32'h0);
      chk($sformatf("v%0d_stall", i), stall_store,
          vt[i].go);
      tick();
      chk($sformatf("v%0d_req", i), data_req, vt[i].go);
      if (vt[i].go) begin
        chk($sformatf("v%0d_strb", i), data_wstrb,
            vt[i].strb);
        chk($sformatf("v%0d_wdata", i), data_wdata,
            vt[i].rep);
        chk($sformatf("v%0d_size", i), data_size,
            vt[i].size);
        chk($sformatf("v%0d_addr", i), data_addr,
            vt[i].addr);
        chk($sformatf("v%0d_wr", i), data_wr, 1'b1);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        #1;
        chk($sformatf("v%0d_rel", i), stall_store, 1'b0);
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        mem_en = 1'b0;
        #1;
        chk($sformatf("v%0d_idle", i), data_req, 1'b0);
      end else begin
        mem_en = 1'b0;
      end
    end

    // SB 0x1003: addr_ok with req, data_ok two later
    sc = 0;
    rc = 0;
    tick();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) put(EXE_SB_OP, 32'h1003, 32'h12345678);
      data_addr_ok = (c == 1);
      data_data_ok = (c == 3);
      #1;
      if (stall_store) sc++;
      if (data_req) rc++;
      if (c == 1) begin
        chk("sb_strb", data_wstrb, 4'b1000);
        chk("sb_wdata", data_wdata, 32'h78787878);
        chk("sb_size", data_size, 2'd0);
        chk("sb_addr", data_addr, 32'h1003);
      end
      tick();
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_en = 1'b0;
    #1;
    chk("sb_stall_cycles", sc, 3);
    chk("sb_req_cycles", rc, 1);
    chk("sb_after_stall", stall_store, 1'b0);

    // flush in REQ with no addr_ok aborts
    tick();
    put(EXE_SW_OP, 32'h4000, 32'hA5A5A5A5);
    #1;
    chk("fl_start", stall_store, 1'b1);
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("fl_req%0d", c), data_req, 1'b1);
      chk($sformatf("fl_stall%0d", c), stall_store, 1'b1);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_en = 1'b0;
    #1;
    chk("fl_req_drop", data_req, 1'b0);
    chk("fl_stall_drop", stall_store, 1'b0);
    tick();
    chk("fl_no_reissue", data_req, 1'b0);

    // flush in the start cycle blocks the store
    put(EXE_SW_OP, 32'h4008, 32'h1);
    flush = 1'b1;
    #1;
    chk("fl0_stall", stall_store, 1'b0);
    tick();
    flush = 1'b0;
    mem_en = 1'b0;
    #1;
    chk("fl0_req", data_req, 1'b0);

    // flush with addr_ok, then flush in WAIT
    tick();
    put(EXE_SW_OP, 32'h4004, 32'h0BADF00D);
    tick();
    data_addr_ok = 1'b1;
    flush = 1'b1;
    #1;
    chk("fw_req", data_req, 1'b1);
    tick();
    data_addr_ok = 1'b0;
    #1;
    chk("fw_wait_req", data_req, 1'b0);
    chk("fw_wait_stall", stall_store, 1'b1);
    tick();
    chk("fw_still_stall", stall_store, 1'b1);
    flush = 1'b0;
    data_data_ok = 1'b1;
    #1;
    chk("fw_rel", stall_store, 1'b0);
    tick();
    data_data_ok = 1'b0;
    mem_en = 1'b0;
    #1;
    chk("fw_idle_stall", stall_store, 1'b0);
    chk("fw_idle_req", data_req, 1'b0);

    // reset during WAIT abandons the write
    tick();
    put(EXE_SW_OP, 32'h6000, 32'h11223344);
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    mem_en = 1'b0;
    #1;
    chk("rw_wait_stall", stall_store, 1'b1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    chk("rw_req", data_req, 1'b0);
    chk("rw_stall", stall_store, 1'b0);
    chk("rw_wstrb", data_wstrb, 4'b0);
    chk("rw_wdata", data_wdata, 32'h0);
    chk("rw_addr", data_addr, 32'h0);
    tick();
    put(EXE_SW_OP, 32'h7000, 32'hCAFEF00D);
    #1;
    chk("rn_start", stall_store, 1'b1);
    tick();
    data_addr_ok = 1'b1;
    #1;
    chk("rn_req", data_req, 1'b1);
    chk("rn_strb", data_wstrb, 4'b1111);
    chk("rn_wdata", data_wdata, 32'hCAFEF00D);
    chk("rn_size", data_size, 2'd2);
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    #1;
    chk("rn_rel", stall_store, 1'b0);
    tick();
    data_data_ok = 1'b0;
    mem_en = 1'b0;
    #1;
    chk("rn_idle", data_req, 1'b0);
    chk("rn_idle_stall", stall_store, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
